// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath and its decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 4;

  // Opcodes carried in IR[7:4]; IR[3:0] is the operand address.
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control word produced by the decoder, one bit per datapath strobe.
  // Field order is also the bit order (hlt is the MSB, j the LSB).
  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic sumo;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
  } ctrl_word_t;

endpackage

// File: rtl/cpu_alu.sv
// Adder/subtractor: result = a + b, or a + ~b + 1 when sub is set.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports: a, b (operands), sub (subtract select), result (truncated sum),
//        carry (bit W of the W+1 bit sum; 1 on subtract means no borrow).
module cpu_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] sum;

  assign sum    = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (W+1)'(sub);
  assign result = sum[W-1:0];
  assign carry  = sum[W];

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 8-bit CPU datapath: registers, program RAM, ALU and bus mux.
// Latency: bus and RAM read are combinational; all captures on the next posedge.
// Backpressure: none; hlt freezes all CPU state, prog_mode hands RAM to the loader.
//
// Ports: clk, rst (async active-low); control strobes hlt..j from the decoder;
//        prog_mode/prog_we/prog_addr/prog_data for program loading;
//        insn (IR), out_val (OUT), pc, flag_c, flag_z, bus_err (sticky conflict).
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              mi,
  input  logic              ri,
  input  logic              ro,
  input  logic              io,
  input  logic              ii,
  input  logic              ai,
  input  logic              ao,
  input  logic              sumo,
  input  logic              sub,
  input  logic              bi,
  input  logic              oi,
  input  logic              ce,
  input  logic              co,
  input  logic              j,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] insn,
  output logic [DATA_W-1:0] out_val,
  output logic [ADDR_W-1:0] pc,
  output logic              flag_c,
  output logic              flag_z,
  output logic              bus_err
);

  ctrl_word_t ctrl;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] out_q;
  logic [ADDR_W-1:0] pc_q;
  logic              flag_c_q;
  logic              flag_z_q;
  logic              bus_err_q;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic [2:0]        drv_cnt;
  logic              cpu_en;

  assign ctrl = '{hlt: hlt, mi: mi, ri: ri, ro: ro, io: io, ii: ii, ai: ai,
                  ao: ao, sumo: sumo, sub: sub, bi: bi, oi: oi, ce: ce,
                  co: co, j: j};

  // CPU-side captures happen only when running and the loader is idle.
  assign cpu_en = ~ctrl.hlt & ~prog_mode;

  assign ram_rd = mem[mar_q];

  assign drv_cnt = 3'(ctrl.ro) + 3'(ctrl.io) + 3'(ctrl.ao) + 3'(ctrl.sumo) + 3'(ctrl.co);

  // Priority mux; a conflict is flagged separately but the winner still drives.
  always_comb begin
    bus = '0;
    if (ctrl.ro)
      bus = ram_rd;
    else if (ctrl.io)
      bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    else if (ctrl.ao)
      bus = a_q;
    else if (ctrl.sumo)
      bus = alu_res;
    else if (ctrl.co)
      bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
  end

  cpu_alu #(
    .W(DATA_W)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sub    (ctrl.sub),
    .result (alu_res),
    .carry  (alu_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar_q     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      pc_q      <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else if (cpu_en) begin
      if (ctrl.mi) mar_q <= bus[ADDR_W-1:0];
      if (ctrl.ii) ir_q  <= bus;
      if (ctrl.ai) a_q   <= bus;
      if (ctrl.bi) b_q   <= bus;
      if (ctrl.oi) out_q <= bus;
      // A jump wins over an increment issued in the same cycle.
      if (ctrl.j)
        pc_q <= bus[ADDR_W-1:0];
      else if (ctrl.ce)
        pc_q <= pc_q + ADDR_W'(1);
      if (ctrl.sumo) begin
        flag_c_q <= alu_c;
        flag_z_q <= (alu_res == '0);
      end
      if (drv_cnt > 3'd1) bus_err_q <= 1'b1;
    end
  end

  // RAM contents survive reset, but no write may land on an edge while
  // reset is held, so the reset edge is in the sensitivity list with no action.
  always_ff @(posedge clk or negedge rst) begin
    if (rst) begin
      if (prog_mode) begin
        if (prog_we) mem[prog_addr] <= prog_data;
      end else if (!ctrl.hlt && ctrl.ri) begin
        mem[mar_q] <= bus;
      end
    end
  end

  assign insn    = ir_q;
  assign out_val = out_q;
  assign pc      = pc_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: directed programs then random control words.
// Latency: expectations are pushed before each posedge and checked 1 ns after it.
// Backpressure: n/a.
module tb_cpu_datapath;
  import cpu_pkg::*;

  localparam logic [14:0] K_HLT  = 15'h4000;
  localparam logic [14:0] K_MI   = 15'h2000;
  localparam logic [14:0] K_RI   = 15'h1000;
  localparam logic [14:0] K_RO   = 15'h0800;
  localparam logic [14:0] K_IO   = 15'h0400;
  localparam logic [14:0] K_II   = 15'h0200;
  localparam logic [14:0] K_AI   = 15'h0100;
  localparam logic [14:0] K_AO   = 15'h0080;
  localparam logic [14:0] K_SUMO = 15'h0040;
  localparam logic [14:0] K_SUB  = 15'h0020;
  localparam logic [14:0] K_BI   = 15'h0010;
  localparam logic [14:0] K_OI   = 15'h0008;
  localparam logic [14:0] K_CE   = 15'h0004;
  localparam logic [14:0] K_CO   = 15'h0002;
  localparam logic [14:0] K_J    = 15'h0001;

  logic       clk = 1'b0;
  logic       rst;
  ctrl_word_t cw;
  logic       prog_mode;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] insn;
  logic [7:0] out_val;
  logic [3:0] pc;
  logic       flag_c;
  logic       flag_z;
  logic       bus_err;

  always #5 clk = ~clk;

  cpu_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hlt       (cw.hlt),
    .mi        (cw.mi),
    .ri        (cw.ri),
    .ro        (cw.ro),
    .io        (cw.io),
    .ii        (cw.ii),
    .ai        (cw.ai),
    .ao        (cw.ao),
    .sumo      (cw.sumo),
    .sub       (cw.sub),
    .bi        (cw.bi),
    .oi        (cw.oi),
    .ce        (cw.ce),
    .co        (cw.co),
    .j         (cw.j),
    .prog_mode (prog_mode),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .insn      (insn),
    .out_val   (out_val),
    .pc        (pc),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .bus_err   (bus_err)
  );

  typedef struct {
    int insn;
    int outv;
    int pc;
    int fc;
    int fz;
    int err;
  } exp_t;

  exp_t q[$];

  // Reference machine state, always "after the most recently issued edge".
  int m_ram[16];
  int m_mar, m_ir, m_a, m_b, m_out, m_pc, m_c, m_z, m_err;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".insn"},    int'(insn),    e.insn);
    chk({tag, ".out_val"}, int'(out_val), e.outv);
    chk({tag, ".pc"},      int'(pc),      e.pc);
    chk({tag, ".flag_c"},  int'(flag_c),  e.fc);
    chk({tag, ".flag_z"},  int'(flag_z),  e.fz);
    chk({tag, ".bus_err"}, int'(bus_err), e.err);
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.insn = m_ir; e.outv = m_out; e.pc = m_pc;
    e.fc = m_c; e.fz = m_z; e.err = m_err;
    return e;
  endfunction

  // One clock edge of the machine described in plain arithmetic.
  task automatic model_step(input logic [14:0] bits, input bit pm, input bit pwe,
                            input int pa, input int pd, input bit rlo);
    ctrl_word_t c;
    int n, sum, carry, bus;
    c = ctrl_word_t'(bits);
    if (rlo) begin
      m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_pc = 0; m_c = 0; m_z = 0; m_err = 0;
      return;
    end
    if (pm) begin
      if (pwe) m_ram[pa] = pd;
      return;
    end
    if (c.hlt) return;
    n = int'(c.ro) + int'(c.io) + int'(c.ao) + int'(c.sumo) + int'(c.co);
    if (c.sub) begin
      sum = (m_a - m_b + 256) % 256;
      carry = (m_a >= m_b) ? 1 : 0;
    end else begin
      sum = (m_a + m_b) % 256;
      carry = (m_a + m_b > 255) ? 1 : 0;
    end
    if (c.ro)        bus = m_ram[m_mar];
    else if (c.io)   bus = m_ir % 16;
    else if (c.ao)   bus = m_a;
    else if (c.sumo) bus = sum;
    else if (c.co)   bus = m_pc;
    else             bus = 0;
    if (c.ri) m_ram[m_mar] = bus;
    if (c.mi) m_mar = bus % 16;
    if (c.ii) m_ir = bus;
    if (c.ai) m_a = bus;
    if (c.bi) m_b = bus;
    if (c.oi) m_out = bus;
    if (c.j)       m_pc = bus % 16;
    else if (c.ce) m_pc = (m_pc + 1) % 16;
    if (c.sumo) begin
      m_c = carry;
      m_z = (sum == 0) ? 1 : 0;
    end
    if (n > 1) m_err = 1;
  endtask

  task automatic cyc_full(input logic [14:0] bits, input bit pm, input bit pwe,
                          input int pa, input int pd, input bit rlo);
    @(negedge clk);
    rst       = ~rlo;
    cw        = ctrl_word_t'(bits);
    prog_mode = pm;
    prog_we   = pwe;
    prog_addr = 4'(pa);
    prog_data = 8'(pd);
    model_step(bits, pm, pwe, pa, pd, rlo);
    q.push_back(snapshot());
  endtask

  task automatic cyc(input logic [14:0] bits);
    cyc_full(bits, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic goto_pc(input int k);
    for (int i = 0; i < 16 && m_pc != k; i++) cyc(K_CE);
  endtask

  // Fetch RAM[addr] into whichever registers dest selects.
  task automatic ld(input int addr, input logic [14:0] dest);
    goto_pc(addr);
    cyc(K_CO | K_MI);
    cyc(K_RO | dest);
  endtask

  task automatic async_reset();
    exp_t z;
    @(negedge clk);
    #2;
    rst = 1'b0;
    cw = ctrl_word_t'(K_RO | K_AI | K_CE | K_RI);
    prog_mode = 1'b0;
    #1;
    model_step('0, 1'b0, 1'b0, 0, 0, 1'b1);
    z = snapshot();
    check_outputs("async_rst", z);
    q.push_back(z);
  endtask

  logic [14:0] drivers[5] = '{K_RO, K_IO, K_AO, K_SUMO, K_CO};

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_outputs("edge", e);
      end
    end
  end

  initial begin : stim
    int prog[16];
    exp_t z;
    logic [14:0] bits;
    int t;
    rst = 1'b0; cw = '0; prog_mode = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0;
    m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_pc = 0; m_c = 0; m_z = 0; m_err = 0;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
    #1;
    z = snapshot();
    check_outputs("reset", z);

    cyc_full('0, 1'b0, 1'b0, 0, 0, 1'b1);
    cyc(15'h0);

    // Program image; unlisted words random.
    for (int i = 0; i < 16; i++) prog[i] = int'($urandom_range(255));
    prog[0] = 'h1E; prog[1] = 'h05; prog[2] = 'hFF; prog[3] = 'h01;
    prog[4] = 'h03; prog[5] = 'h2A; prog[6] = 'h09; prog[7] = 'h07;
    prog[14] = 'h07;
    for (int i = 0; i < 16; i++) cyc_full(15'h0, 1'b1, 1'b1, i, prog[i], 1'b0);
    // Loader strobe without prog_mode must not touch RAM[14].
    cyc_full(15'h0, 1'b0, 1'b1, 14, 'h55, 1'b0);

    // Fetch from address 0: insn = 1E.
    cyc(K_CO | K_MI);
    cyc(K_RO | K_II);

    // ADD 07 + 05, then FF + 01.
    ld(7, K_AI); ld(1, K_BI); cyc(K_SUMO | K_AI); cyc(K_AO | K_OI);
    ld(2, K_AI); ld(3, K_BI); cyc(K_SUMO | K_AI); cyc(K_AO | K_OI);
    // SUB 05 - 05, then 03 - 05.
    ld(1, K_AI); ld(1, K_BI); cyc(K_SUB | K_SUMO | K_AI); cyc(K_AO | K_OI);
    ld(4, K_AI); cyc(K_SUB | K_SUMO | K_AI); cyc(K_AO | K_OI);

    // PC wrap, jump over increment, halt freeze.
    goto_pc(15); cyc(K_CE);
    ld(6, K_J | K_CE);
    cyc(K_HLT | K_CE | K_AO | K_RO | K_OI);

    // Bus conflict: RAM (09) wins, error sticks.
    cyc(K_RO | K_AO | K_OI);
    cyc(15'h0);
    cyc(K_CE);

    // Mid-run async reset with A=2A and PC=6.
    ld(5, K_AI); cyc(K_AO | K_OI); goto_pc(6);
    async_reset();
    cyc(15'h0);
    // RAM survived: RAM[0]=1E and RAM[14]=07.
    cyc(K_CO | K_MI); cyc(K_RO | K_II);
    cyc(K_IO | K_MI); cyc(K_RO | K_OI);

    // Random control words.
    for (int i = 0; i < 400; i++) begin
      bits = 15'($urandom & $urandom) & (K_MI | K_RI | K_II | K_AI | K_SUB | K_BI |
                                         K_OI | K_CE | K_J);
      if ($urandom_range(5) != 0) bits |= drivers[$urandom_range(4)];
      if ($urandom_range(9) == 0) bits |= drivers[$urandom_range(4)];
      if ($urandom_range(9) == 0) bits |= K_HLT;
      cyc_full(bits, ($urandom_range(9) == 0), 1'($urandom), int'($urandom_range(15)),
               int'($urandom_range(255)), ($urandom_range(49) == 0));
    end

    t = 0;
    while (q.size() > 0 && t < 10) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (q.size() > 0) chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 Parameter DATA_W, 8, bus/register width.
REQ-002 Parameter ADDR_W, 4, RAM address, MAR and PC width; RAM depth 2**ADDR_W.
REQ-003 clk  input  1  single clock; one clock only, all datapath registers and RAM capture on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j  input  1 each  control word from the decoder; changes on negedge clk.
REQ-006 prog_mode  input  1  program-load mode.
REQ-007 prog_we  input  1  RAM write strobe, used only when prog_mode=1.
REQ-008 prog_addr  input  ADDR_W  program-load address.
REQ-009 prog_data  input  DATA_W  program-load data.
REQ-010 insn  output  DATA_W  instruction register contents, feeds decoder.
REQ-011 out_val  output  DATA_W  output register contents.
REQ-012 pc  output  ADDR_W  program counter.
REQ-013 flag_c, flag_z  output  1 each  carry and zero flags.
REQ-014 bus_err  output  1  sticky flag: more than one bus driver seen.

Function
REQ-015 Bus is combinational: drivers in priority ro (RAM[MAR]) > io ({0,IR[3:0]}) > ao (A) > sumo (ALU result) > co ({0,PC}); no driver -> bus = 0.
REQ-016 Two or more of ro/io/ao/sumo/co high while hlt=0 and prog_mode=0 at a posedge -> bus_err set to 1 and held until reset; the priority winner is still used.
REQ-017 ALU: sub=0 -> A+B, sub=1 -> A+~B+1; result truncated to DATA_W; carry = bit DATA_W of the (DATA_W+1)-bit sum.
REQ-018 At posedge with hlt=0 and prog_mode=0: mi -> MAR<=bus[ADDR_W-1:0]; ri -> RAM[MAR]<=bus; ii -> IR<=bus; ai -> A<=bus; bi -> B<=bus; oi -> OUT<=bus.
REQ-019 PC: j -> PC<=bus[ADDR_W-1:0]; else ce -> PC<=PC+1, wrapping 15->0; j overrides ce in the same cycle.
REQ-020 Flags: at a posedge with sumo=1 (not halted), flag_c<=ALU carry and flag_z<=(ALU result==0); otherwise the flags hold.
REQ-021 All captures in one cycle use pre-edge values: mi+ri writes to the old MAR, and ai+sumo loads A with old A plus/minus old B.
REQ-022 hlt=1 freezes MAR, IR, A, B, OUT, PC, flags, RAM CPU writes and bus_err updates.
REQ-023 prog_mode=1: CPU captures are suppressed; prog_we=1 at a posedge -> RAM[prog_addr]<=prog_data; prog_we is ignored when prog_mode=0.
REQ-024 RAM read is asynchronous: RAM[MAR] reflects a write from the previous posedge.
REQ-025 Outputs are direct register values: insn=IR, out_val=OUT, pc=PC.

Reset
REQ-026 rst=0 asynchronously clears PC, MAR, IR, A, B, OUT, flag_c, flag_z and bus_err to 0.
REQ-027 RAM contents are not reset; a program loaded before a reset survives it.
REQ-028 Reset asserted mid-instruction or mid-program-load aborts any capture on that edge; there is no partial write.
REQ-029 Normal captures resume at the first posedge after rst rises.

Structure
REQ-030 Shared package cpu_pkg holds DATA_W/ADDR_W defaults, opcode constants (LDA=4'b0001, ADD=4'b0010, OUT=4'b1110, HLT=4'b1111) and a packed control-word typedef shared with the decoder.
REQ-031 One sub-module: cpu_alu (combinational A, B, sub -> result, carry), instantiated once.
REQ-032 The RAM is inferred in cpu_datapath as a 2**ADDR_W x DATA_W array.

Verification
REQ-033 Program load: prog_mode=1, write RAM[0]=8'h1E, RAM[14]=8'h07 -> a read via mi(bus=co, PC=0) then ro+ii gives insn=8'h1E.
REQ-034 ADD: A=8'h07, B=8'h05, sumo+ai -> A=8'h0C, flag_c=0, flag_z=0; A=8'hFF, B=8'h01 -> A=8'h00, flag_c=1, flag_z=1.
REQ-035 SUB: A=8'h05, B=8'h05, sub+sumo+ai -> A=8'h00, flag_c=1, flag_z=1; A=8'h03, B=8'h05 -> A=8'hFE, flag_c=0.
REQ-036 PC: PC=15 with ce -> PC=0; ce+j with bus=8'h09 -> PC=9; hlt=1 with ce -> PC unchanged.
REQ-037 Conflict: ro+ao together -> bus = RAM[MAR], bus_err=1, which stays 1 after the signals clear and drops only on rst=0.
REQ-038 Reset: rst=0 pulsed mid-run with A=8'h2A, PC=6 -> all registers 0 immediately and RAM[14] still 8'h07.
